// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box tables, round constants, GF(2^8) helpers
// and the decrypt FSM encoding.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEYEXP   = 3'd1,
    INIT_ARK = 3'd2,
    ROUNDS   = 3'd3,
    FINAL    = 3'd4
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
      8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
      8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
      8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
      8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
      8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
      8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
      8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
      8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
      8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
      8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
      8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
      8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
      8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
      8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
      8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
      8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
      8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
      8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
      8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
      8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
      8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
      8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
      8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
      8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
      8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
      8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
      8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
      8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
      8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
      8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
      8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction

  // Index 0 and 11..15 are never consumed; they return 0 so idle cycles stay benign.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    case (rnd)
      4'd1:  r = 8'h01;
      4'd2:  r = 8'h02;
      4'd3:  r = 8'h04;
      4'd4:  r = 8'h08;
      4'd5:  r = 8'h10;
      4'd6:  r = 8'h20;
      4'd7:  r = 8'h40;
      4'd8:  r = 8'h80;
      4'd9:  r = 8'h1b;
      4'd10: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] result
);

  logic [7:0] s [16];
  logic [7:0] t [16];
  logic [7:0] m [16];

  always_comb begin
    for (int i = 0; i < 16; i++) s[i] = state[127-8*i -: 8];
    // Byte (row r, column c) sits at index 4c+r; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[4*c+r] = inv_sbox(s[4*((c - r + 4) % 4) + r]) ^ round_key[127-8*(4*c+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      m[4*c+0] = gmul(t[4*c+0], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
      m[4*c+1] = gmul(t[4*c+0], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
      m[4*c+2] = gmul(t[4*c+0], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
      m[4*c+3] = gmul(t[4*c+0], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
    end
    result = '0;
    for (int i = 0; i < 16; i++) result[127-8*i -: 8] = last ? t[i] : m[i];
  end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: expands the key forward to rk10, then runs
// ten inverse rounds one per clock while walking the key schedule backwards.
module aes128_decrypt_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext_in,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic         done,
  output logic [127:0] plaintext_out
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_e       fsm_q, fsm_d;
  logic [127:0] blk_q;
  logic [127:0] key_q;
  logic [3:0]   cnt_q;
  logic         done_q;
  logic [127:0] pt_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w1p, w2p, w3p;
  logic [31:0]  sub_in, rot, kmix;
  logic [31:0]  fw0, fw1, fw2, fw3;
  logic [127:0] key_fwd, key_inv;
  logic [127:0] rnd_out;

  assign {w0, w1, w2, w3} = key_q;
  assign w3p = w3 ^ w2;
  assign w2p = w2 ^ w1;
  assign w1p = w1 ^ w0;

  // Forward expansion feeds SubWord from w3; the backward step needs the
  // recovered previous w3, so one set of four S-boxes serves both directions.
  assign sub_in = (fsm_q == KEYEXP) ? w3 : w3p;
  assign rot    = {sub_in[23:0], sub_in[31:24]};
  assign kmix   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                ^ {rcon(cnt_q), 24'h000000};

  assign fw0 = w0 ^ kmix;
  assign fw1 = w1 ^ fw0;
  assign fw2 = w2 ^ fw1;
  assign fw3 = w3 ^ fw2;
  assign key_fwd = {fw0, fw1, fw2, fw3};
  assign key_inv = {w0 ^ kmix, w1p, w2p, w3p};

  aes_inv_round u_round (
    .state     (blk_q),
    .round_key (key_q),
    .last      (fsm_q == FINAL),
    .result    (rnd_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    ready = 1'b0;
    case (fsm_q)
      IDLE: begin
        ready = 1'b1;
        if (start) fsm_d = KEYEXP;
      end
      KEYEXP:   if (cnt_q == LAST_RND) fsm_d = INIT_ARK;
      INIT_ARK: fsm_d = ROUNDS;
      ROUNDS:   if (cnt_q == 4'd1) fsm_d = FINAL;
      FINAL:    fsm_d = IDLE;
      default:  fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q  <= '0;
      key_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      pt_q   <= '0;
    end else begin
      done_q <= (fsm_q == FINAL);
      case (fsm_q)
        IDLE: begin
          if (start) begin
            blk_q <= ciphertext_in;
            key_q <= key_in;
            cnt_q <= 4'd1;
          end
        end
        KEYEXP: begin
          key_q <= key_fwd;
          if (cnt_q != LAST_RND) cnt_q <= cnt_q + 4'd1;
        end
        INIT_ARK: begin
          blk_q <= blk_q ^ key_q;
          key_q <= key_inv;
          cnt_q <= LAST_RND - 4'd1;
        end
        ROUNDS: begin
          blk_q <= rnd_out;
          key_q <= key_inv;
          cnt_q <= cnt_q - 4'd1;
        end
        FINAL:   pt_q <= rnd_out;
        default: ;
      endcase
    end
  end

  assign done          = done_q;
  assign plaintext_out = pt_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed bench for aes128_decrypt_iter using the FIPS-197 App. B and C.1 vectors.
module tb_aes128_decrypt_iter;

  localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10C = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] ct = '0;
  logic [127:0] key = '0;
  logic         ready;
  logic         done;
  logic [127:0] pt;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  aes128_decrypt_iter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .ciphertext_in (ct),
    .key_in        (key),
    .ready         (ready),
    .done          (done),
    .plaintext_out (pt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] c, input logic [127:0] k);
    ct = c;
    key = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: quiet inputs; 1: busy start pulses at T+5/T+15; 2: random inputs each cycle
  task automatic run(input logic [127:0] c, input logic [127:0] k, input int mode,
                     output logic busy0, output int lat, output logic [127:0] k10,
                     output logic [127:0] res, output logic rdy);
    accept(c, k);
    busy0 = ready;
    lat = -1;
    k10 = '0;
    res = '0;
    rdy = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      if (mode == 1) begin
        start = (n == 5 || n == 15);
        ct = CC;
        key = KC;
      end else if (mode == 2) begin
        ct = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      start = 1'b0;
      if (n == 10) k10 = dut.key_q;
      if (done) begin
        lat = n;
        res = pt;
        rdy = ready;
      end
    end
  endtask

  initial begin
    logic         busy0, rdy;
    int           lat, d1, d2, bad, extra;
    logic [127:0] k10, res, p1, p2;

    #12;
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_done", 128'(done), 128'd0);
    check("rst_pt", pt, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run(CB, KB, 0, busy0, lat, k10, res, rdy);
    check("b_busy", 128'(busy0), 128'd0);
    check("b_latency", 128'(lat), 128'd21);
    check("b_rk10", k10, RK10B);
    check("b_pt", res, PB);
    check("b_ready_in_done", 128'(rdy), 128'd1);
    tick();
    check("b_done_pulse", 128'(done), 128'd0);
    check("b_pt_hold", pt, PB);

    run(CC, KC, 0, busy0, lat, k10, res, rdy);
    check("c_latency", 128'(lat), 128'd21);
    check("c_rk10", k10, RK10C);
    check("c_pt", res, PC);
    tick();

    // back-to-back: start stays high so the done cycle also accepts the next block
    ct = CB;
    key = KB;
    start = 1'b1;
    tick();
    ct = CC;
    key = KC;
    d1 = -1;
    d2 = -1;
    bad = 0;
    p1 = '0;
    p2 = '0;
    for (int n = 1; n <= 60 && d2 < 0; n++) begin
      tick();
      if (d1 >= 0) start = 1'b0;
      if (ready !== done) bad++;
      if (done) begin
        if (d1 < 0) begin
          d1 = n;
          p1 = pt;
        end else begin
          d2 = n;
          p2 = pt;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_latency", 128'(d1), 128'd21);
    check("b2b_first_pt", p1, PB);
    check("b2b_spacing", 128'(d2 - d1), 128'd22);
    check("b2b_second_pt", p2, PC);
    check("b2b_ready_only_idle", 128'(bad), 128'd0);
    tick();

    run(CB, KB, 1, busy0, lat, k10, res, rdy);
    check("busy_latency", 128'(lat), 128'd21);
    check("busy_pt", res, PB);
    extra = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done) extra++;
    end
    check("busy_no_extra_done", 128'(extra), 128'd0);

    run(CB, KB, 2, busy0, lat, k10, res, rdy);
    check("vol_latency", 128'(lat), 128'd21);
    check("vol_pt", res, PB);
    tick();

    accept(CC, KC);
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    check("abort_ready", 128'(ready), 128'd1);
    check("abort_done", 128'(done), 128'd0);
    check("abort_pt", pt, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run(CC, KC, 0, busy0, lat, k10, res, rdy);
    check("post_abort_latency", 128'(lat), 128'd21);
    check("post_abort_pt", res, PC);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
